crc_checker: RTL and testbench
==============================

Name: crc_checker

Overview:
Serial CRC-8 receiver/checker. It is the far-end counterpart of the team's serial CRC generator and uses the same polynomial taps, seed and LSB-first bit order. It consumes a serial payload, then the 8 transmitted CRC bits. It reports pass/fail and framing errors to the link-layer receive controller.

Parameters:
SEED, 8'hD8, LFSR initial value; must match the transmitter's SEED.

Ports:
CLK  input  1  module clock; all logic on rising edge
RST  input  1  asynchronous, active-low reset
DATA_IN  input  1  serial line bit: payload bit or CRC bit
DATA_EN  input  1  high while DATA_IN carries a payload bit
CRC_EN  input  1  high while DATA_IN carries a received CRC bit (LSB first)
BUSY  output  1  high in PAYLOAD or CHECK state
DONE  output  1  one-cycle pulse when a frame check completes or aborts
CRC_OK  output  1  result of the last completed frame; held until the next DONE
FRAME_ERR  output  1  one-cycle pulse, coincident with DONE, on a framing violation

Behaviour:
- Reset (async, RST=0):
  - state=IDLE, LFSR=SEED, bit count=0, mismatch flag=0.
  - BUSY=0, DONE=0, CRC_OK=0, FRAME_ERR=0.
- LFSR payload update is identical to the generator's. With fb = DATA_IN ^ LFSR[0], the next LFSR is {fb, LFSR[7]^fb, LFSR[6:4], LFSR[3]^fb, LFSR[2:1]}.
- CRC compare step:
  - mismatch |= DATA_IN ^ LFSR[0].
  - Then LFSR shifts right with zero fill: {1'b0, LFSR[7:1]}.
  - The 3-bit count increments.
- Registered outputs: DONE, FRAME_ERR and CRC_OK update on the clock edge that leaves CHECK or aborts.
- IDLE:
  - DATA_EN=1, CRC_EN=0: apply payload update to LFSR; go to PAYLOAD.
  - CRC_EN=1 (with or without DATA_EN): framing error (zero-length payload). Pulse DONE and FRAME_ERR, CRC_OK<=0, stay IDLE, LFSR stays SEED.
  - Both low: hold.
- PAYLOAD:
  - DATA_EN=1, CRC_EN=0: payload update, stay.
  - Both low: gap; hold LFSR, stay. Gaps of any length are legal and cover the transmitter's one-cycle output register delay.
  - CRC_EN=1, DATA_EN=0: first compare step (count becomes 1); go to CHECK.
  - Both high: framing error; abort as defined below.
- CHECK:
  - CRC_EN=1, DATA_EN=0: compare step.
  - Completion: on the step that consumes the 8th CRC bit (count was 7), the next cycle shows DONE=1, CRC_OK=~(final mismatch), FRAME_ERR=0. The state returns to IDLE with LFSR=SEED, count=0, mismatch=0.
  - CRC_EN=0 before 8 bits (CRC bits must be contiguous), or DATA_EN=1 at any point: framing error; abort.
- Abort:
  - DONE=1, FRAME_ERR=1, CRC_OK=0 next cycle.
  - State returns to IDLE with LFSR/count/mismatch reinitialised.
  - Input bits in the aborting cycle are discarded.
- Latency: DONE is asserted 1 cycle after the last CRC bit is sampled.
- Back-to-back frames: DATA_EN may be high in the same cycle DONE is high. That bit is the first payload bit of the new frame, taken from SEED.
- A correct frame always ends with LFSR=8'h00 after 8 compare steps. This is a useful verification assertion; the design's pass criterion is the mismatch flag.
- BUSY = (state != IDLE), registered with the state.
- Reset asserted mid-frame: everything returns immediately to reset values. No DONE is produced for the interrupted frame.

Test Plan:
- Single payload bit 0, then CRC bits 0,0,1,1,0,1,1,0 on consecutive cycles -> DONE=1 and CRC_OK=1 one cycle after the 8th bit; FRAME_ERR=0; internal LFSR after payload = 8'h6C.
- Single payload bit 1, then CRC bits 0,0,0,1,0,1,0,1 -> CRC_OK=1 (LFSR after payload = 8'hA8). Repeat with the 4th CRC bit flipped -> CRC_OK=0, FRAME_ERR=0.
- Loopback against the team's CRC generator with SEED=8'hD8: random 1-64-bit payloads, generator Valid driving CRC_EN, one-cycle gap between payload and CRC -> CRC_OK=1 for every frame. Inject a single payload bit flip -> CRC_OK=0.
- Framing errors:
  - CRC_EN drops after 5 CRC bits -> DONE=FRAME_ERR=1, CRC_OK=0.
  - CRC_EN=1 in IDLE -> same response.
  - DATA_EN and CRC_EN high together -> same response.
  - In each case the next good frame passes.
- Back-to-back: a new frame's DATA_EN rises in the DONE cycle -> the second frame is checked correctly from SEED (CRC_OK=1).
- RST pulsed low during the 3rd CRC bit -> all outputs 0 immediately, no DONE, the following frame passes.

Source files
------------

// File: rtl/crc_checker.sv
// Serial CRC-8 receiver/checker.
// Consumes an LSB-first serial payload followed by the 8 transmitted CRC bits.
// Reports pass/fail and framing violations to the receive controller.
module crc_checker #(
    parameter logic [7:0] SEED = 8'hD8
) (
    input  logic CLK,
    input  logic RST,
    input  logic DATA_IN,
    input  logic DATA_EN,
    input  logic CRC_EN,
    output logic BUSY,
    output logic DONE,
    output logic CRC_OK,
    output logic FRAME_ERR
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_CHECK   = 2'd2
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_lfsr,  w_lfsr_nxt;
    logic [2:0] r_cnt,   w_cnt_nxt;
    logic       r_mis,   w_mis_nxt;
    logic       r_busy;
    logic       r_done,  w_done_nxt;
    logic       r_ok,    w_ok_nxt;
    logic       r_ferr,  w_ferr_nxt;

    logic       w_fb;
    logic [7:0] w_lfsr_upd;
    logic [7:0] w_lfsr_shr;
    logic       w_bit_mis;

    // Payload feedback matches the transmitter; compare path drains the LFSR.
    assign w_fb       = DATA_IN ^ r_lfsr[0];
    assign w_lfsr_upd = {w_fb, r_lfsr[7] ^ w_fb, r_lfsr[6:4], r_lfsr[3] ^ w_fb, r_lfsr[2:1]};
    assign w_lfsr_shr = {1'b0, r_lfsr[7:1]};
    assign w_bit_mis  = DATA_IN ^ r_lfsr[0];

    // Next-state, datapath and result decode; abort discards the current bit.
    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_nxt  = r_lfsr;
        w_cnt_nxt   = r_cnt;
        w_mis_nxt   = r_mis;
        w_done_nxt  = 1'b0;
        w_ferr_nxt  = 1'b0;
        w_ok_nxt    = r_ok;
        case (r_state)
            S_IDLE: begin
                if (CRC_EN) begin
                    // Zero-length payload: report and stay idle from SEED.
                    w_done_nxt = 1'b1;
                    w_ferr_nxt = 1'b1;
                    w_ok_nxt   = 1'b0;
                end else if (DATA_EN) begin
                    w_lfsr_nxt  = w_lfsr_upd;
                    w_state_nxt = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (DATA_EN && CRC_EN) begin
                    w_done_nxt  = 1'b1;
                    w_ferr_nxt  = 1'b1;
                    w_ok_nxt    = 1'b0;
                    w_state_nxt = S_IDLE;
                    w_lfsr_nxt  = SEED;
                    w_cnt_nxt   = 3'd0;
                    w_mis_nxt   = 1'b0;
                end else if (DATA_EN) begin
                    w_lfsr_nxt = w_lfsr_upd;
                end else if (CRC_EN) begin
                    w_mis_nxt   = r_mis | w_bit_mis;
                    w_lfsr_nxt  = w_lfsr_shr;
                    w_cnt_nxt   = 3'd1;
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (DATA_EN || !CRC_EN) begin
                    // CRC bits must be contiguous and uncontaminated by payload.
                    w_done_nxt  = 1'b1;
                    w_ferr_nxt  = 1'b1;
                    w_ok_nxt    = 1'b0;
                    w_state_nxt = S_IDLE;
                    w_lfsr_nxt  = SEED;
                    w_cnt_nxt   = 3'd0;
                    w_mis_nxt   = 1'b0;
                end else if (r_cnt == 3'd7) begin
                    w_done_nxt  = 1'b1;
                    w_ok_nxt    = ~(r_mis | w_bit_mis);
                    w_state_nxt = S_IDLE;
                    w_lfsr_nxt  = SEED;
                    w_cnt_nxt   = 3'd0;
                    w_mis_nxt   = 1'b0;
                end else begin
                    w_mis_nxt  = r_mis | w_bit_mis;
                    w_lfsr_nxt = w_lfsr_shr;
                    w_cnt_nxt  = r_cnt + 3'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_lfsr_nxt  = SEED;
                w_cnt_nxt   = 3'd0;
                w_mis_nxt   = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs; async reset clears everything.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_lfsr  <= SEED;
            r_cnt   <= 3'd0;
            r_mis   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ok    <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mis   <= w_mis_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= w_done_nxt;
            r_ok    <= w_ok_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign CRC_OK    = r_ok;
    assign FRAME_ERR = r_ferr;

endmodule

// File: tb/tb_crc_checker.sv
// Directed bench for crc_checker: table of frames plus framing/reset sequences.
module tb_crc_checker;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic DATA_IN = 1'b0;
    logic DATA_EN = 1'b0;
    logic CRC_EN = 1'b0;
    logic BUSY, DONE, CRC_OK, FRAME_ERR;

    int nchk = 0;
    int nerr = 0;

    crc_checker #(.SEED(8'hD8)) dut (
        .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .DATA_EN(DATA_EN),
        .CRC_EN(CRC_EN), .BUSY(BUSY), .DONE(DONE), .CRC_OK(CRC_OK),
        .FRAME_ERR(FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          n;
        logic [63:0] pay;
        logic [7:0]  crc;
        bit          gap;
        bit          exp_ok;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic idle();
        DATA_EN = 1'b0;
        CRC_EN  = 1'b0;
        DATA_IN = 1'b0;
    endtask

    // Generator reference: payload LFSR from SEED, result is the CRC byte.
    function automatic logic [7:0] gen_crc(input int n, input logic [63:0] pay);
        logic [7:0] l;
        logic fb;
        l = 8'hD8;
        for (int i = 0; i < n; i++) begin
            fb = pay[i] ^ l[0];
            l  = {fb, l[7] ^ fb, l[6:4], l[3] ^ fb, l[2:1]};
        end
        return l;
    endfunction

    // Drives payload, optional gap, then 8 CRC bits; leaves inputs on the last bit.
    task automatic run_frame(input int n, input logic [63:0] pay, input logic [7:0] crc,
                             input bit gap);
        for (int i = 0; i < n; i++) begin
            DATA_EN = 1'b1; CRC_EN = 1'b0; DATA_IN = pay[i];
            step();
        end
        if (gap) begin
            idle();
            step();
        end
        for (int i = 0; i < 8; i++) begin
            DATA_EN = 1'b0; CRC_EN = 1'b1; DATA_IN = crc[i];
            step();
        end
    endtask

    task automatic chk_result(input string name, input bit ok, input bit ferr);
        chk({name, ".done"}, DONE, 1'b1);
        chk({name, ".ok"},   CRC_OK, ok);
        chk({name, ".ferr"}, FRAME_ERR, ferr);
    endtask

    initial begin
        // Hand-computed: D8 -bit0-> 6C, D8 -bit1-> A8, 6C -bit1-> F2, A8 -bit1-> 90.
        vecs[0] = '{1, 64'h0, 8'h6C, 1'b0, 1'b1};
        vecs[1] = '{1, 64'h1, 8'hA8, 1'b0, 1'b1};
        vecs[2] = '{1, 64'h1, 8'hA0, 1'b0, 1'b0};  // 4th CRC bit flipped
        vecs[3] = '{2, 64'h2, 8'hF2, 1'b1, 1'b1};
        vecs[4] = '{2, 64'h2, 8'hF3, 1'b1, 1'b0};
        vecs[5] = '{2, 64'h3, 8'hF2, 1'b0, 1'b0};  // payload bit flipped
        vecs[6] = '{1, 64'h0, 8'h6C, 1'b1, 1'b1};

        #2;
        chk("rst.busy", BUSY, 1'b0);
        chk("rst.done", DONE, 1'b0);
        chk("rst.ok",   CRC_OK, 1'b0);
        chk("rst.ferr", FRAME_ERR, 1'b0);
        #10 RST = 1'b1;
        step();

        for (int v = 0; v < 7; v++) begin
            DATA_EN = 1'b1; CRC_EN = 1'b0; DATA_IN = vecs[v].pay[0];
            step();
            chk($sformatf("vec%0d.busy", v), BUSY, 1'b1);
            run_frame(vecs[v].n - 1, vecs[v].pay >> 1, vecs[v].crc, vecs[v].gap);
            chk_result($sformatf("vec%0d", v), vecs[v].exp_ok, 1'b0);
            idle();
            step();
            chk($sformatf("vec%0d.pulse", v), DONE, 1'b0);
            chk($sformatf("vec%0d.idle", v), BUSY, 1'b0);
        end

        // Loopback frames against the generator reference, one gap cycle.
        for (int k = 0; k < 6; k++) begin
            int n;
            logic [63:0] pay;
            logic [7:0] crc;
            n   = $urandom_range(1, 64);
            pay = {$urandom, $urandom};
            crc = gen_crc(n, pay);
            if (k == 5) pay[$urandom_range(0, n - 1)] ^= 1'b1;
            run_frame(n, pay, crc, 1'b1);
            chk_result($sformatf("loop%0d", k), k != 5, 1'b0);
            idle();
            step();
        end

        // CRC_EN drops after 5 CRC bits.
        DATA_EN = 1'b1; DATA_IN = 1'b0; step();
        for (int i = 0; i < 5; i++) begin
            DATA_EN = 1'b0; CRC_EN = 1'b1; DATA_IN = (8'h6C >> i) & 1;
            step();
        end
        chk("drop.done_early", DONE, 1'b0);
        idle(); step();
        chk_result("drop", 1'b0, 1'b1);
        chk("drop.busy", BUSY, 1'b0);
        step();
        run_frame(1, 64'h1, 8'hA8, 1'b0);
        chk_result("drop.next", 1'b1, 1'b0);
        idle(); step();

        // CRC_EN in IDLE.
        CRC_EN = 1'b1; DATA_EN = 1'b1; DATA_IN = 1'b1; step();
        chk_result("idlecrc", 1'b0, 1'b1);
        chk("idlecrc.busy", BUSY, 1'b0);
        idle(); step();
        chk("idlecrc.pulse", FRAME_ERR, 1'b0);
        run_frame(1, 64'h0, 8'h6C, 1'b0);
        chk_result("idlecrc.next", 1'b1, 1'b0);
        idle(); step();

        // DATA_EN and CRC_EN together mid-payload.
        DATA_EN = 1'b1; DATA_IN = 1'b0; step();
        CRC_EN = 1'b1; step();
        chk_result("both", 1'b0, 1'b1);
        idle(); step();
        run_frame(2, 64'h2, 8'hF2, 1'b0);
        chk_result("both.next", 1'b1, 1'b0);
        idle(); step();

        // Back-to-back: second frame starts in the DONE cycle, from SEED.
        run_frame(1, 64'h0, 8'h6C, 1'b0);
        chk_result("b2b.first", 1'b1, 1'b0);
        run_frame(1, 64'h1, 8'hA8, 1'b0);
        chk_result("b2b.second", 1'b1, 1'b0);
        idle(); step();

        // Reset during the 3rd CRC bit.
        DATA_EN = 1'b1; DATA_IN = 1'b0; step();
        for (int i = 0; i < 3; i++) begin
            DATA_EN = 1'b0; CRC_EN = 1'b1; DATA_IN = (8'h6C >> i) & 1;
            if (i < 2) step();
        end
        #2 RST = 1'b0;
        #1;
        chk("rstmid.busy", BUSY, 1'b0);
        chk("rstmid.done", DONE, 1'b0);
        chk("rstmid.ok",   CRC_OK, 1'b0);
        chk("rstmid.ferr", FRAME_ERR, 1'b0);
        idle();
        #3 RST = 1'b1;
        step();
        step();
        chk("rstmid.nodone", DONE, 1'b0);
        run_frame(1, 64'h1, 8'hA8, 1'b1);
        chk_result("rstmid.next", 1'b1, 1'b0);
        idle(); step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
